// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped prescaled up-counter with compare match,
// one-shot / auto-reload and a level interrupt, on the picoRV32 iomem bus.
//
// Ports:
//   clk, resetn            system clock, async active-low reset
//   iomem_valid/ready      bus request / one-cycle acknowledge
//   iomem_wstrb            byte write strobes (0 = read)
//   iomem_addr/wdata       byte address / write data
//   iomem_rdata            read data, nonzero only while iomem_ready=1
//   irq_out                MATCH & IRQEN, registered
//   pwm_out                only when TIMER_PWM_EN is defined
//
// Register map (addr[4:2]): 0 CTRL{IRQEN,RELOAD,EN}, 1 COMPARE, 2 COUNT,
// 3 PRESCALE, 4 STATUS{MATCH, W1C}, 5 DUTY (TIMER_PWM_EN only), 6-7 reserved.
// Optional feature macro: TIMER_PWM_EN.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          CNT_W     = 32,
  parameter int          PRE_W     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
`ifdef TIMER_PWM_EN
  ,
  output logic        pwm_out
`endif
);

  logic             en_q, en_d, reload_q, reload_d, irqen_q, irqen_d;
  logic             match_q, match_d, irq_q, ready_q;
  logic [CNT_W-1:0] compare_q, compare_d, count_q, count_d;
  logic [PRE_W-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic [31:0]      rdata_q, rdata_d, rd_mux;
  logic             sel, acc, wr, tick, match_set, w1c;
  logic [2:0]       off;
`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q;
`endif

  logic unused_addr;
  assign unused_addr = ^{iomem_addr[7:5], iomem_addr[1:0]};

  // Replace the bytes of a 32-bit view of a register selected by the strobes.
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  // Accept only while not already acknowledging: one ack per two cycles.
  assign acc = sel && !ready_q;
  assign wr  = acc && (iomem_wstrb != 4'b0000);
  assign off = iomem_addr[4:2];

  always_comb begin
    rd_mux = '0;
    case (off)
      3'd0:    rd_mux = {29'd0, irqen_q, reload_q, en_q};
      3'd1:    rd_mux = 32'(compare_q);
      3'd2:    rd_mux = 32'(count_q);
      3'd3:    rd_mux = 32'(prescale_q);
      3'd4:    rd_mux = {31'd0, match_q};
`ifdef TIMER_PWM_EN
      3'd5:    rd_mux = 32'(duty_q);
`endif
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    reload_d   = reload_q;
    irqen_d    = irqen_q;
    compare_d  = compare_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    match_set  = 1'b0;
    w1c        = 1'b0;
`ifdef TIMER_PWM_EN
    duty_d     = duty_q;
`endif
    tick      = en_q && (pre_cnt_q == prescale_q);
    // pre_cnt wraps naturally if PRESCALE was lowered below it.
    pre_cnt_d = (!en_q || tick) ? '0 : pre_cnt_q + PRE_W'(1);
    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        if (reload_q) count_d = '0;
        else          en_d    = 1'b0;  // one-shot: COUNT holds at COMPARE
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    // Bus writes come last so they override tick effects in the same cycle.
    if (wr) begin
      case (off)
        3'd0: if (iomem_wstrb[0]) begin
          en_d     = iomem_wdata[0];
          reload_d = iomem_wdata[1];
          irqen_d  = iomem_wdata[2];
        end
        3'd1: compare_d  = CNT_W'(wmerge(32'(compare_q), iomem_wdata, iomem_wstrb));
        3'd2: count_d    = CNT_W'(wmerge(32'(count_q), iomem_wdata, iomem_wstrb));
        3'd3: prescale_d = PRE_W'(wmerge(32'(prescale_q), iomem_wdata, iomem_wstrb));
        3'd4: w1c        = iomem_wstrb[0] && iomem_wdata[0];
`ifdef TIMER_PWM_EN
        3'd5: duty_d     = CNT_W'(wmerge(32'(duty_q), iomem_wdata, iomem_wstrb));
`endif
        default: ;
      endcase
    end
    // A match set in the same cycle as a W1C wins.
    match_d = match_set || (match_q && !w1c);
    rdata_d = (acc && !wr) ? rd_mux : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q <= 1'b0; reload_q <= 1'b0; irqen_q <= 1'b0;
      match_q <= 1'b0; irq_q <= 1'b0; ready_q <= 1'b0;
      compare_q <= '0; count_q <= '0; prescale_q <= '0; pre_cnt_q <= '0;
      rdata_q <= '0;
`ifdef TIMER_PWM_EN
      duty_q <= '0; pwm_q <= 1'b0;
`endif
    end else begin
      en_q <= en_d; reload_q <= reload_d; irqen_q <= irqen_d;
      match_q <= match_d;
      irq_q <= match_q && irqen_q;
      ready_q <= acc;
      compare_q <= compare_d; count_q <= count_d;
      prescale_q <= prescale_d; pre_cnt_q <= pre_cnt_d;
      rdata_q <= rdata_d;
`ifdef TIMER_PWM_EN
      duty_q <= duty_d;
      pwm_q  <= en_q && (count_q < duty_q);
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq_out     = irq_q;
`ifdef TIMER_PWM_EN
  assign pwm_out     = pwm_q;
`endif

endmodule
